// File: rtl/rs_decode_sequencer.sv
`default_nettype none
// ============================================================================
// rs_decode_sequencer : frame controller for the RS(15,11) GF(16) decoder
// Rev 1.0
// ============================================================================
module rs_decode_sequencer #(
    parameter int N       = 15,
    parameter int SYM_W   = 4,
    parameter int T       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_sym,
    output logic             syn_clr,
    output logic             syn_en,
    input  logic             synd_done,
    input  logic             synd_zero,
    output logic             kes_start,
    input  logic             kes_done,
    input  logic             kes_fail,
    output logic             ep_control,
    input  logic             ep_valid,
    input  logic [SYM_W-1:0] ep_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last,
    output logic             out_uncorr,
    output logic             busy
);

    localparam int IDX_W = $clog2(N);
    localparam int WC_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] c_LAST    = IDX_W'(N - 1);
    localparam logic [WC_W-1:0]  c_TO_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [1:0]       c_NZ_MAX  = 2'd3;
    localparam logic [1:0]       c_T       = 2'(T);

    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_SYND_WAIT = 3'd1,
        S_KES_WAIT  = 3'd2,
        S_EP_RUN    = 3'd3,
        S_EMIT      = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [SYM_W-1:0]  r_buf [N];
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_ep_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [1:0]        r_nz;
    logic              r_uncorr;
    logic              r_syn_clr;

    logic              w_live;
    logic              w_accept;
    logic              w_ep_beat;
    logic              w_hs;
    logic              w_timeout;
    logic              w_in_wait;
    logic              w_wait_entry;
    logic              w_to_load;
    logic              w_uncorr_nx;
    logic [1:0]        w_nz_nx;

    // Every output is forced low while RESET is held.
    assign w_live     = !RESET;
    assign in_ready   = w_live && (r_state == S_LOAD);
    assign w_accept   = in_valid && in_ready;
    assign syn_en     = w_accept;
    assign syn_clr    = w_live && r_syn_clr;
    assign kes_start  = w_live && (r_state == S_KES_WAIT) && (r_wait_cnt == '0);
    assign ep_control = w_live && (r_state == S_EP_RUN) && (r_wait_cnt == '0);
    assign w_ep_beat  = w_live && (r_state == S_EP_RUN) && ep_valid;
    assign out_valid  = w_live && (r_state == S_EMIT);
    assign w_hs       = out_valid && out_ready;
    assign out_sym    = out_valid ? r_buf[r_rd_idx] : '0;
    assign out_last   = out_valid && (r_rd_idx == c_LAST);
    assign out_uncorr = out_valid && r_uncorr;
    assign busy       = w_live && (r_state != S_LOAD);

    assign w_timeout = (r_wait_cnt == c_TO_LAST);
    assign w_in_wait = (r_state == S_SYND_WAIT) || (r_state == S_KES_WAIT) ||
                       (r_state == S_EP_RUN);
    assign w_nz_nx   = ((ep_value != '0) && (r_nz != c_NZ_MAX)) ? r_nz + 2'd1 : r_nz;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Completion is tested before timeout so a same-cycle completion wins.
    always_comb begin
        w_state_nx   = r_state;
        w_wait_entry = 1'b0;
        w_to_load    = 1'b0;
        w_uncorr_nx  = r_uncorr;
        case (r_state)
            S_LOAD: begin
                if (w_accept && (r_wr_idx == c_LAST)) begin
                    w_state_nx   = S_SYND_WAIT;
                    w_wait_entry = 1'b1;
                end
            end
            S_SYND_WAIT: begin
                if (synd_done) begin
                    if (synd_zero) begin
                        w_state_nx  = S_EMIT;
                        w_uncorr_nx = 1'b0;
                    end else begin
                        w_state_nx   = S_KES_WAIT;
                        w_wait_entry = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx  = S_EMIT;
                    w_uncorr_nx = 1'b1;
                end
            end
            S_KES_WAIT: begin
                if (kes_done) begin
                    if (kes_fail) begin
                        w_state_nx  = S_EMIT;
                        w_uncorr_nx = 1'b1;
                    end else begin
                        w_state_nx   = S_EP_RUN;
                        w_wait_entry = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nx  = S_EMIT;
                    w_uncorr_nx = 1'b1;
                end
            end
            S_EP_RUN: begin
                if (w_ep_beat && (r_ep_idx == c_LAST)) begin
                    w_state_nx  = S_EMIT;
                    w_uncorr_nx = (w_nz_nx > c_T);
                end else if (w_timeout) begin
                    w_state_nx  = S_EMIT;
                    w_uncorr_nx = 1'b1;
                end
            end
            S_EMIT: begin
                if (w_hs && (r_rd_idx == c_LAST)) begin
                    w_state_nx  = S_LOAD;
                    w_to_load   = 1'b1;
                    w_uncorr_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_idx   <= '0;
            r_ep_idx   <= '0;
            r_rd_idx   <= '0;
            r_wait_cnt <= '0;
            r_nz       <= '0;
            r_uncorr   <= 1'b0;
            r_syn_clr  <= 1'b1;
        end else begin
            r_syn_clr <= w_to_load;
            r_uncorr  <= w_uncorr_nx;
            if (w_to_load) begin
                r_wr_idx <= '0;
                r_ep_idx <= '0;
                r_rd_idx <= '0;
                r_nz     <= '0;
            end else begin
                if (w_accept) begin
                    r_wr_idx <= r_wr_idx + IDX_W'(1);
                end
                if (w_ep_beat) begin
                    r_ep_idx <= r_ep_idx + IDX_W'(1);
                    r_nz     <= w_nz_nx;
                end
                if (w_hs) begin
                    r_rd_idx <= r_rd_idx + IDX_W'(1);
                end
            end
            if (w_wait_entry || w_to_load) begin
                r_wait_cnt <= '0;
            end else if (w_in_wait) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
        end
    end

    // Symbol storage carries no reset; its contents only matter once loaded.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_buf[r_wr_idx] <= in_sym;
        end else if (w_ep_beat) begin
            r_buf[r_ep_idx] <= r_buf[r_ep_idx] ^ ep_value;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_decode_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rs_decode_sequencer : directed table-driven bench for rs_decode_sequencer
// Rev 1.0
// ============================================================================
module tb_rs_decode_sequencer;

    localparam logic [2:0] M_SZ  = 3'd0;  // syndromes zero
    localparam logic [2:0] M_KF  = 3'd1;  // key-equation failure
    localparam logic [2:0] M_EP  = 3'd2;  // full correction path
    localparam logic [2:0] M_STO = 3'd3;  // syndrome timeout
    localparam logic [2:0] M_KTO = 3'd4;  // key-equation timeout

    typedef struct packed {
        logic [59:0] word;
        logic [2:0]  mode;
        logic [59:0] ep;
        logic        gap;
        logic [59:0] exp_word;
        logic        exp_uncorr;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sym;
    logic       syn_clr;
    logic       syn_en;
    logic       synd_done;
    logic       synd_zero;
    logic       kes_start;
    logic       kes_done;
    logic       kes_fail;
    logic       ep_control;
    logic       ep_valid;
    logic [3:0] ep_value;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sym;
    logic       out_last;
    logic       out_uncorr;
    logic       busy;

    int n_pass = 0;
    int n_chk  = 0;
    int kes_cnt = 0;
    int epc_cnt = 0;
    int sen_cnt = 0;

    vec_t vecs [7];

    rs_decode_sequencer #(.N(15), .SYM_W(4), .T(2), .TIMEOUT(64)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .syn_clr(syn_clr), .syn_en(syn_en),
        .synd_done(synd_done), .synd_zero(synd_zero),
        .kes_start(kes_start), .kes_done(kes_done), .kes_fail(kes_fail),
        .ep_control(ep_control), .ep_valid(ep_valid), .ep_value(ep_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .out_last(out_last), .out_uncorr(out_uncorr), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (kes_start)  kes_cnt <= kes_cnt + 1;
        if (ep_control) epc_cnt <= epc_cnt + 1;
        if (syn_en)     sen_cnt <= sen_cnt + 1;
    end

    function automatic logic [3:0] sym(input logic [59:0] w, input int i);
        return w[4*(14-i) +: 4];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [14:0] all_outputs();
        return {in_ready, syn_clr, syn_en, kes_start, ep_control, out_valid,
                out_sym, out_last, out_uncorr, busy};
    endfunction

    task automatic load_word(input logic [59:0] w);
        int guard;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_sym   = sym(w, i);
            guard    = 0;
            while (!in_ready && guard < 50) begin
                @(negedge CLK);
                guard++;
            end
            @(negedge CLK);
        end
        in_valid = 1'b0;
    endtask

    task automatic measure_timeout(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge CLK);
            lat++;
        end
        check(name, lat, 64);
    endtask

    task automatic run_frame(input vec_t v, input int id);
        int          ks0, ec0, se0, k, guard;
        logic [59:0] got;
        logic [14:0] lastmask;
        logic        ubad;
        string       tag;
        tag = $sformatf("v%0d", id);
        // Stray completions while loading must be ignored.
        synd_done = 1'b1; synd_zero = 1'b1; kes_done = 1'b1; kes_fail = 1'b1;
        ep_valid  = 1'b1; ep_value  = 4'hF;
        @(negedge CLK);
        synd_done = 1'b0; synd_zero = 1'b0; kes_done = 1'b0; kes_fail = 1'b0;
        ep_valid  = 1'b0; ep_value  = 4'h0;
        ks0 = kes_cnt; ec0 = epc_cnt; se0 = sen_cnt;

        load_word(v.word);
        check({tag, "_in_ready_after_load"}, {in_ready, busy}, 2'b01);

        if (v.mode == M_STO) begin
            measure_timeout({tag, "_synd_timeout_lat"});
        end else begin
            repeat (3) @(negedge CLK);
            synd_done = 1'b1;
            synd_zero = (v.mode == M_SZ);
            @(negedge CLK);
            synd_done = 1'b0;
            synd_zero = 1'b0;
            if (v.mode == M_KTO) begin
                measure_timeout({tag, "_kes_timeout_lat"});
            end else if (v.mode != M_SZ) begin
                repeat (2) @(negedge CLK);
                kes_done = 1'b1;
                kes_fail = (v.mode == M_KF);
                @(negedge CLK);
                kes_done = 1'b0;
                kes_fail = 1'b0;
                if (v.mode == M_EP) begin
                    for (int i = 0; i < 15; i++) begin
                        ep_valid = 1'b1;
                        ep_value = sym(v.ep, i);
                        @(negedge CLK);
                        if (v.gap) begin
                            ep_valid = 1'b0;
                            @(negedge CLK);
                        end
                    end
                    ep_valid = 1'b1;
                    ep_value = 4'h7;
                    repeat (2) @(negedge CLK);
                    ep_valid = 1'b0;
                    ep_value = 4'h0;
                end
            end
        end

        got = '0; lastmask = '0; ubad = 1'b0; k = 0; guard = 0;
        out_ready = 1'b1;
        while (k < 15 && guard < 300) begin
            if (out_valid) begin
                got[4*(14-k) +: 4] = out_sym;
                lastmask[k]        = out_last;
                if (out_uncorr !== v.exp_uncorr) ubad = 1'b1;
                k++;
            end
            @(negedge CLK);
            guard++;
        end
        out_ready = 1'b0;

        check({tag, "_word"}, got, v.exp_word);
        check({tag, "_uncorr"}, ubad, 1'b0);
        check({tag, "_last_pos"}, lastmask, 15'h4000);
        check({tag, "_kes_start_cycles"}, kes_cnt - ks0,
              (v.mode == M_KF || v.mode == M_EP || v.mode == M_KTO) ? 1 : 0);
        check({tag, "_ep_control_cycles"}, epc_cnt - ec0, (v.mode == M_EP) ? 1 : 0);
        check({tag, "_syn_en_beats"}, sen_cnt - se0, 15);
        check({tag, "_back_to_load"}, {syn_clr, in_ready, busy, out_valid}, 4'b1100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] hold;
        logic       bad;
        int         guard;

        vecs[0] = '{60'h0, M_SZ, 60'h0, 1'b0, 60'h0, 1'b0};
        vecs[1] = '{60'h0123456789ABCDE, M_EP, 60'h000500000000000, 1'b0,
                    60'h0126456789ABCDE, 1'b0};
        vecs[2] = '{60'h123456789ABCDEF, M_EP, 60'hF00000000000006, 1'b1,
                    60'hE23456789ABCDE9, 1'b0};
        vecs[3] = '{60'hA5A5A5A5A5A5A5A, M_KF, 60'h0, 1'b0,
                    60'hA5A5A5A5A5A5A5A, 1'b1};
        vecs[4] = '{60'h0123456789ABCDE, M_EP, 60'h100200300000000, 1'b0,
                    60'h1121455789ABCDE, 1'b1};
        vecs[5] = '{60'h3C3C3C3C3C3C3C3, M_STO, 60'h0, 1'b0,
                    60'h3C3C3C3C3C3C3C3, 1'b1};
        vecs[6] = '{60'h0F0F0F0F0F0F0F0, M_KTO, 60'h0, 1'b0,
                    60'h0F0F0F0F0F0F0F0, 1'b1};

        RESET = 1'b1; in_valid = 1'b0; in_sym = '0; synd_done = 1'b0; synd_zero = 1'b0;
        kes_done = 1'b0; kes_fail = 1'b0; ep_valid = 1'b0; ep_value = '0; out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("outputs_in_reset", all_outputs(), 15'h0);
        RESET = 1'b0;
        #1;
        check("first_cycle_after_reset", {syn_clr, in_ready, busy, out_valid}, 4'b1100);
        @(negedge CLK);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Output stall followed by a mid-frame reset.
        load_word(60'h0123456789ABCDE);
        repeat (2) @(negedge CLK);
        synd_done = 1'b1; synd_zero = 1'b1;
        @(negedge CLK);
        synd_done = 1'b0; synd_zero = 1'b0;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        out_ready = 1'b0;
        hold = out_sym;
        bad  = 1'b0;
        check("stall_sym", hold, 4'h3);
        repeat (5) begin
            @(negedge CLK);
            if (out_sym !== hold || !out_valid) bad = 1'b1;
        end
        check("stall_hold", bad, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge CLK);
        check("sym_before_reset", out_sym, 4'h7);
        RESET = 1'b1;
        #1;
        check("outputs_mid_reset", all_outputs(), 15'h0);
        @(negedge CLK);
        out_ready = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("after_mid_reset", {syn_clr, in_ready, busy, out_valid}, 4'b1100);
        @(negedge CLK);
        run_frame(vecs[2], 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
